isa_io_master: RTL

ISA_IO_MASTER -- requirements
Module: isa_io_master

---
 rtl/isa_io_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/isa_io_master.sv
// ISA bus I/O-cycle master: a single host command becomes a SETUP -> STROBE -> HOLD bus cycle.
// Define ISA_IOCHRDY_EN to add the IOCHRDY input and bounded strobe stretching with a timeout.
module isa_io_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int WAIT_LIMIT    = 64
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [9:0] SA,
  inout  wire  [7:0] SD,
  output logic       IOR,
  output logic       IOW,
  output logic       AEN
`ifdef ISA_IOCHRDY_EN
  ,
  input  logic       IOCHRDY
`endif
);

  localparam int S_CYC = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
  localparam int T_CYC = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int H_CYC = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
  // One counter serves every phase, including the stretched tail of STROBE.
  localparam int CNT_W = $clog2(S_CYC + T_CYC + H_CYC + WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S_CYC - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T_CYC - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             write_reg;
  logic [7:0]       wdata_reg;
  logic             sd_oe_reg;
  logic [7:0]       rdata_reg;
  logic             err_reg;
  logic [9:0]       sa_reg;
  logic             ior_reg;
  logic             iow_reg;
  logic             aen_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic [7:0]       rsp_rdata_reg;
  logic             rsp_err_reg;
  logic             stretch;
  logic             timeout;

`ifdef ISA_IOCHRDY_EN
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(T_CYC - 1 + WAIT_LIMIT);
  // Keep stretching while the target holds IOCHRDY low, until the wait budget is spent.
  assign stretch = !IOCHRDY && (cnt_reg != X_LAST);
  assign timeout = !IOCHRDY;
`else
  assign stretch = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      write_reg     <= 1'b0;
      wdata_reg     <= 8'h00;
      sd_oe_reg     <= 1'b0;
      rdata_reg     <= 8'h00;
      err_reg       <= 1'b0;
      sa_reg        <= 10'h000;
      ior_reg       <= 1'b1;
      iow_reg       <= 1'b1;
      aen_reg       <= 1'b1;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            write_reg     <= cmd_write;
            wdata_reg     <= cmd_wdata;
            sa_reg        <= cmd_addr;
            sd_oe_reg     <= cmd_write;
            aen_reg       <= 1'b0;
            cmd_ready_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_reg == S_LAST) begin
            cnt_reg   <= '0;
            ior_reg   <= write_reg;
            iow_reg   <= !write_reg;
            state_reg <= STROBE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STROBE: begin
          if (cnt_reg < T_LAST || stretch) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            // Read data is captured on the edge that ends the strobe.
            if (!write_reg) rdata_reg <= timeout ? 8'hFF : SD;
            err_reg   <= timeout;
            ior_reg   <= 1'b1;
            iow_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_reg == H_LAST) begin
            if (!write_reg) rsp_rdata_reg <= rdata_reg;
            rsp_err_reg   <= err_reg;
            rsp_valid_reg <= 1'b1;
            aen_reg       <= 1'b1;
            sd_oe_reg     <= 1'b0;
            cmd_ready_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign SD        = sd_oe_reg ? wdata_reg : 8'hzz;
  assign SA        = sa_reg;
  assign IOR       = ior_reg;
  assign IOW       = iow_reg;
  assign AEN       = aen_reg;
  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
